// File: rtl/e_reg_ctrl.sv
// Execute-stage pipeline register with hazard control and saturating performance counters.
// The E register is bubbled (loaded with a nop) on load-use or mispredict, never stalled.
module e_reg_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  d_stat,
  input  logic [3:0]  d_icode,
  input  logic [3:0]  d_ifun,
  input  logic [63:0] d_valC,
  input  logic [63:0] d_valA,
  input  logic [63:0] d_valB,
  input  logic [3:0]  d_dstE,
  input  logic [3:0]  d_dstM,
  input  logic [3:0]  d_srcA,
  input  logic [3:0]  d_srcB,
  input  logic [3:0]  D_icode,
  input  logic [3:0]  M_icode,
  input  logic        e_Cnd,
  input  logic [1:0]  m_stat,
  input  logic [1:0]  W_stat,
  output logic [1:0]  E_stat,
  output logic [3:0]  E_icode,
  output logic [3:0]  E_ifun,
  output logic [63:0] E_valC,
  output logic [63:0] E_valA,
  output logic [63:0] E_valB,
  output logic [3:0]  E_dstE,
  output logic [3:0]  E_dstM,
  output logic [3:0]  E_srcA,
  output logic [3:0]  E_srcB,
  output logic        F_stall,
  output logic        D_stall,
  output logic        D_bubble,
  output logic        E_bubble,
  output logic        M_bubble,
  output logic        W_stall,
  output logic [31:0] cyc_cnt,
  output logic [31:0] bub_cnt,
  output logic [31:0] stl_cnt
);
  localparam logic [3:0] I_NOP   = 4'h1;
  localparam logic [3:0] I_MRMOV = 4'h5;
  localparam logic [3:0] I_JXX   = 4'h7;
  localparam logic [3:0] I_RET   = 4'h9;
  localparam logic [3:0] I_POP   = 4'hB;
  localparam logic [3:0] R_NONE  = 4'hF;

  logic [1:0]  r_e_stat;
  logic [3:0]  r_e_icode, r_e_ifun;
  logic [63:0] r_e_valC, r_e_valA, r_e_valB;
  logic [3:0]  r_e_dstE, r_e_dstM, r_e_srcA, r_e_srcB;
  logic [31:0] r_cyc_cnt, r_bub_cnt, r_stl_cnt;

  logic w_load_use, w_mispredict, w_ret_pend;
  logic w_f_stall, w_d_stall, w_d_bubble, w_e_bubble, w_m_bubble, w_w_stall;

  always_comb begin
    w_load_use   = ((r_e_icode == I_MRMOV) || (r_e_icode == I_POP)) && (r_e_dstM != R_NONE) &&
                   ((r_e_dstM == d_srcA) || (r_e_dstM == d_srcB));
    w_mispredict = (r_e_icode == I_JXX) && !e_Cnd;
    w_ret_pend   = (D_icode == I_RET) || (r_e_icode == I_RET) || (M_icode == I_RET);
    w_f_stall    = w_load_use || w_ret_pend;
    w_d_stall    = w_load_use;
    // Mispredict squashes the decode slot even when a load-use also holds.
    w_d_bubble   = w_mispredict || (w_ret_pend && !w_load_use);
    w_e_bubble   = w_mispredict || w_load_use;
    w_m_bubble   = (m_stat != 2'd0) || (W_stat != 2'd0);
    w_w_stall    = (W_stat != 2'd0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst || w_e_bubble) begin
      r_e_stat  <= 2'd0;
      r_e_icode <= I_NOP;
      r_e_ifun  <= 4'd0;
      r_e_valC  <= 64'd0;
      r_e_valA  <= 64'd0;
      r_e_valB  <= 64'd0;
      r_e_dstE  <= R_NONE;
      r_e_dstM  <= R_NONE;
      r_e_srcA  <= R_NONE;
      r_e_srcB  <= R_NONE;
    end else begin
      r_e_stat  <= d_stat;
      r_e_icode <= d_icode;
      r_e_ifun  <= d_ifun;
      r_e_valC  <= d_valC;
      r_e_valA  <= d_valA;
      r_e_valB  <= d_valB;
      r_e_dstE  <= d_dstE;
      r_e_dstM  <= d_dstM;
      r_e_srcA  <= d_srcA;
      r_e_srcB  <= d_srcB;
    end
  end

  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
    return (en && (v != 32'hFFFF_FFFF)) ? v + 32'd1 : v;
  endfunction

  // Counters freeze while the write-back stage reports a non-AOK status.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cyc_cnt <= 32'd0;
      r_bub_cnt <= 32'd0;
      r_stl_cnt <= 32'd0;
    end else if (W_stat == 2'd0) begin
      r_cyc_cnt <= sat_inc(r_cyc_cnt, 1'b1);
      r_bub_cnt <= sat_inc(r_bub_cnt, w_e_bubble || w_d_bubble);
      r_stl_cnt <= sat_inc(r_stl_cnt, w_f_stall);
    end
  end

  assign E_stat   = r_e_stat;
  assign E_icode  = r_e_icode;
  assign E_ifun   = r_e_ifun;
  assign E_valC   = r_e_valC;
  assign E_valA   = r_e_valA;
  assign E_valB   = r_e_valB;
  assign E_dstE   = r_e_dstE;
  assign E_dstM   = r_e_dstM;
  assign E_srcA   = r_e_srcA;
  assign E_srcB   = r_e_srcB;
  assign F_stall  = w_f_stall;
  assign D_stall  = w_d_stall;
  assign D_bubble = w_d_bubble;
  assign E_bubble = w_e_bubble;
  assign M_bubble = w_m_bubble;
  assign W_stall  = w_w_stall;
  assign cyc_cnt  = r_cyc_cnt;
  assign bub_cnt  = r_bub_cnt;
  assign stl_cnt  = r_stl_cnt;
endmodule

// File: doc/e_reg_ctrl.md
E_REG_CTRL -- requirements
Module: e_reg_ctrl

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have inputs d_stat[1:0], d_icode[3:0], d_ifun[3:0], d_valC[63:0], d_valA[63:0], d_valB[63:0], d_dstE[3:0], d_dstM[3:0], d_srcA[3:0], d_srcB[3:0]: decode-stage results to be latched.
REQ-004 SHALL have inputs D_icode[3:0], M_icode[3:0], e_Cnd (1 bit), m_stat[1:0], W_stat[1:0]: hazard sources.
REQ-005 SHALL have outputs E_stat, E_icode, E_ifun, E_valC, E_valA, E_valB, E_dstE, E_dstM, E_srcA, E_srcB, with widths matching the d_* inputs: the registered execute-stage inputs.
REQ-006 SHALL have outputs F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, each 1 bit: pipeline control.
REQ-007 SHALL have outputs cyc_cnt[31:0], bub_cnt[31:0], stl_cnt[31:0]: performance counters.

Function
REQ-008 SHALL use encodings: stat 0=AOK, 1=HLT, 2=ADR, 3=INS; icode 1=nop, 5=mrmovq, 7=jXX, 9=ret, B=popq; register F=none.
REQ-009 SHALL compute load_use = (E_icode==5 or E_icode==B) and E_dstM!=F and (E_dstM==d_srcA or E_dstM==d_srcB).
REQ-010 SHALL compute mispredict = (E_icode==7 and e_Cnd==0).
REQ-011 SHALL compute ret_pend = (D_icode==9 or E_icode==9 or M_icode==9).
REQ-012 SHALL drive F_stall = load_use or ret_pend, combinationally from current inputs/state.
REQ-013 SHALL drive D_stall = load_use.
REQ-014 SHALL drive D_bubble = mispredict or (ret_pend and not load_use).
REQ-015 SHALL drive E_bubble = mispredict or load_use.
REQ-016 SHALL drive M_bubble = (m_stat!=0) or (W_stat!=0), and W_stall = (W_stat!=0).
REQ-017 On each rising edge with E_bubble=0, SHALL load all E_* from the corresponding d_*; latency is 1 cycle.
REQ-018 On each rising edge with E_bubble=1, SHALL load a nop: E_stat=0, E_icode=1, E_ifun=0, E_val*=0, E_dstE/E_dstM/E_srcA/E_srcB=F.
REQ-019 SHALL give E_bubble priority over loading; the E register is never stalled.
REQ-020 SHALL increment cyc_cnt by 1 every edge while W_stat==0.
REQ-021 SHALL increment bub_cnt on every edge where E_bubble=1 or D_bubble=1, while W_stat==0.
REQ-022 SHALL increment stl_cnt on every edge where F_stall=1, while W_stat==0.
REQ-023 SHALL saturate every counter at 32'hFFFFFFFF, with no wrap.
REQ-024 SHALL freeze all counters while W_stat!=0; the E register keeps updating per REQ-017/018.
REQ-025 When load_use and mispredict hold together, SHALL bubble E once (REQ-015) and assert D_bubble=1 and D_stall=1; downstream gives D_bubble precedence.

Reset
REQ-026 While rst=1, SHALL force E_* to the nop values of REQ-018, and set cyc_cnt, bub_cnt and stl_cnt to 0, independent of clk.
REQ-027 After reset, control outputs SHALL follow REQ-012..016 from the reset E_* state (E_icode=1 gives no load_use, no mispredict).
REQ-028 Reset asserted mid-operation SHALL discard any in-flight E contents; the first edge after release loads d_* normally.

Verification
REQ-029 Reset: rst=1 -> E_icode=1, E_dstE=F, E_srcA=F, E_valA=0, all counters 0, E_bubble=0.
REQ-030 Pass-through: d_icode=6, d_valA=5, d_valB=7, d_dstE=3, no hazards -> one edge later E_icode=6, E_valA=5, E_valB=7, E_dstE=3; cyc_cnt=1.
REQ-031 Load-use: E_icode=5, E_dstM=2, d_srcA=2 -> F_stall=1, D_stall=1, E_bubble=1; next edge E_icode=1; stl_cnt and bub_cnt each +1.
REQ-032 Mispredict: E_icode=7, e_Cnd=0 -> D_bubble=1, E_bubble=1, F_stall=0; next edge E_icode=1.
REQ-033 Ret: D_icode=9, no load_use -> F_stall=1, D_bubble=1, E_bubble=0; with load_use also true -> D_bubble=0, D_stall=1.
REQ-034 Halt and saturation: W_stat=1 -> W_stall=1, M_bubble=1, counters hold; cyc_cnt preset to FFFFFFFF with W_stat=0 -> stays FFFFFFFF.
